// File: rtl/systolic_pe_mac.sv
// Weight-stationary systolic PE: double-buffered weight, signed MAC with saturate/wrap,
// one-cycle east pass-through and a held result with a valid/ready drain handshake.
module systolic_pe_mac #(
    parameter int DATA_W   = 8,
    parameter int WEIGHT_W = 8,
    parameter int ACC_W    = 20,
    parameter int SAT_EN   = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DATA_W-1:0]   data_in,
    input  logic                data_in_valid,
    output logic                in_ready,
    output logic [DATA_W-1:0]   data_out,
    output logic                data_out_valid,
    input  logic [WEIGHT_W-1:0] weight_in,
    input  logic                weight_load,
    input  logic                weight_swap,
    input  logic [DATA_W-1:0]   bias_in,
    input  logic                bias_en,
    input  logic                acc_en,
    input  logic                acc_last,
    output logic [ACC_W-1:0]    result,
    output logic                result_sat,
    output logic                result_valid,
    input  logic                result_ready
);

    localparam int PROD_W = DATA_W + WEIGHT_W;
    localparam int SUM_W  = ACC_W + 1;

    if (ACC_W < PROD_W) begin : g_bad_acc_w
        $error("systolic_pe_mac: ACC_W must be >= DATA_W + WEIGHT_W");
    end

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic accept;
    logic mac;
    logic mac_last;

    logic [WEIGHT_W-1:0] shadow_w;
    logic [WEIGHT_W-1:0] active_w;

    logic [ACC_W-1:0] acc;
    logic             acc_sat;

    logic [PROD_W-1:0] data_ext;
    logic [PROD_W-1:0] weight_ext;
    logic [PROD_W-1:0] product;
    logic [ACC_W-1:0]  bias_ext;
    logic [ACC_W-1:0]  base;
    logic              base_sat;
    logic [SUM_W-1:0]  sum;
    logic [ACC_W-1:0]  sum_fit;
    logic              clamp;

    // Handshake: only a result stuck waiting on the consumer blocks the west input.
    assign result_valid = (state == HOLD);
    assign in_ready     = !(result_valid && !result_ready);
    assign accept       = data_in_valid && in_ready;
    assign mac          = accept && acc_en;
    assign mac_last     = mac && acc_last;

    // Full-width signed product; operands are sign-extended to PROD_W so the
    // low PROD_W bits of the unsigned multiply are the exact signed product.
    always_comb begin
        data_ext   = {{WEIGHT_W{data_in[DATA_W-1]}}, data_in};
        weight_ext = {{DATA_W{active_w[WEIGHT_W-1]}}, active_w};
        product    = data_ext * weight_ext;
        bias_ext   = {{(ACC_W-DATA_W){bias_in[DATA_W-1]}}, bias_in};
    end

    // A bias on the same beat as a MAC starts a fresh accumulation.
    always_comb begin
        base     = acc;
        base_sat = acc_sat;
        if (bias_en) begin
            base     = bias_ext;
            base_sat = 1'b0;
        end
    end

    // One guard bit is enough: both addends are within the ACC_W signed range.
    always_comb begin
        sum     = {base[ACC_W-1], base} + {{(SUM_W-PROD_W){product[PROD_W-1]}}, product};
        sum_fit = sum[ACC_W-1:0];
        clamp   = 1'b0;
        if (SAT_EN != 0) begin
            if (!sum[SUM_W-1] && sum[ACC_W-1]) begin
                sum_fit = {1'b0, {(ACC_W-1){1'b1}}};
                clamp   = 1'b1;
            end else if (sum[SUM_W-1] && !sum[ACC_W-1]) begin
                sum_fit = {1'b1, {(ACC_W-1){1'b0}}};
                clamp   = 1'b1;
            end
        end
    end

    // Swap reads the pre-load shadow, so load+swap moves the old shadow into active.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_w <= '0;
            active_w <= '0;
        end else begin
            if (weight_load) begin
                shadow_w <= weight_in;
            end
            if (weight_swap) begin
                active_w <= shadow_w;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out       <= '0;
            data_out_valid <= 1'b0;
        end else begin
            data_out_valid <= accept;
            if (accept) begin
                data_out <= data_in;
            end
        end
    end

    // A lone bias is also frozen while a result is blocked, like the rest of the datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            acc_sat <= 1'b0;
        end else if (mac_last) begin
            acc     <= '0;
            acc_sat <= 1'b0;
        end else if (mac) begin
            acc     <= sum_fit;
            acc_sat <= base_sat || clamp;
        end else if (bias_en && in_ready) begin
            acc     <= bias_ext;
            acc_sat <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result     <= '0;
            result_sat <= 1'b0;
        end else if (mac_last) begin
            result     <= sum_fit;
            result_sat <= (SAT_EN != 0) && (base_sat || clamp);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // A pop coinciding with a new final beat stays in HOLD so the result reloads without a bubble.
    always_comb begin
        state_next = state;
        case (state)
            RUN: begin
                if (mac_last) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (mac_last) begin
                    state_next = HOLD;
                end else if (result_ready) begin
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

endmodule

// File: tb/tb_systolic_pe_mac.sv
// Drives three PE configurations (20-bit saturating, 16-bit saturating, 16-bit wrapping)
// from shared inputs and compares them every cycle against an arithmetic reference model.
module tb_systolic_pe_mac;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [7:0] data_in;
    logic [7:0] weight_in;
    logic [7:0] bias_in;
    logic       data_in_valid;
    logic       weight_load;
    logic       weight_swap;
    logic       bias_en;
    logic       acc_en;
    logic       acc_last;
    logic       result_ready;

    logic       in_ready       [3];
    logic [7:0] data_out       [3];
    logic       data_out_valid [3];
    logic       result_sat     [3];
    logic       result_valid   [3];
    logic [19:0] result_a;
    logic [15:0] result_b;
    logic [15:0] result_c;

    systolic_pe_mac #(.DATA_W(8), .WEIGHT_W(8), .ACC_W(20), .SAT_EN(1)) u_dut (
        .clk(clk), .rst(rst),
        .data_in(data_in), .data_in_valid(data_in_valid), .in_ready(in_ready[0]),
        .data_out(data_out[0]), .data_out_valid(data_out_valid[0]),
        .weight_in(weight_in), .weight_load(weight_load), .weight_swap(weight_swap),
        .bias_in(bias_in), .bias_en(bias_en), .acc_en(acc_en), .acc_last(acc_last),
        .result(result_a), .result_sat(result_sat[0]), .result_valid(result_valid[0]),
        .result_ready(result_ready)
    );

    systolic_pe_mac #(.DATA_W(8), .WEIGHT_W(8), .ACC_W(16), .SAT_EN(1)) u_sat16 (
        .clk(clk), .rst(rst),
        .data_in(data_in), .data_in_valid(data_in_valid), .in_ready(in_ready[1]),
        .data_out(data_out[1]), .data_out_valid(data_out_valid[1]),
        .weight_in(weight_in), .weight_load(weight_load), .weight_swap(weight_swap),
        .bias_in(bias_in), .bias_en(bias_en), .acc_en(acc_en), .acc_last(acc_last),
        .result(result_b), .result_sat(result_sat[1]), .result_valid(result_valid[1]),
        .result_ready(result_ready)
    );

    systolic_pe_mac #(.DATA_W(8), .WEIGHT_W(8), .ACC_W(16), .SAT_EN(0)) u_wrap16 (
        .clk(clk), .rst(rst),
        .data_in(data_in), .data_in_valid(data_in_valid), .in_ready(in_ready[2]),
        .data_out(data_out[2]), .data_out_valid(data_out_valid[2]),
        .weight_in(weight_in), .weight_load(weight_load), .weight_swap(weight_swap),
        .bias_in(bias_in), .bias_en(bias_en), .acc_en(acc_en), .acc_last(acc_last),
        .result(result_c), .result_sat(result_sat[2]), .result_valid(result_valid[2]),
        .result_ready(result_ready)
    );

    int test_count = 0;
    int fail_count = 0;

    int cfg_w   [3] = '{20, 16, 16};
    bit cfg_sat [3] = '{1'b1, 1'b1, 1'b0};

    longint m_acc  [3];
    bit     m_sat  [3];
    longint m_res  [3];
    bit     m_rsat [3];
    bit     m_rvalid;
    longint m_shadow;
    longint m_active;
    longint m_dout;
    bit     m_doutv;

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        test_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    function automatic longint dutResult(input int k);
        case (k)
            0:       return longint'($signed(result_a));
            1:       return longint'($signed(result_b));
            default: return longint'($signed(result_c));
        endcase
    endfunction

    // Saturating clamp or modular wrap of an exact integer into a w-bit signed range.
    function automatic longint fitValue(input int w, input bit sat_en, input longint s,
                                        output bit clamped);
        longint hi = (longint'(1) <<< (w - 1)) - 1;
        longint lo = -(longint'(1) <<< (w - 1));
        longint m  = longint'(1) <<< w;
        longint r;
        clamped = 1'b0;
        if (sat_en) begin
            if (s > hi) begin
                clamped = 1'b1;
                return hi;
            end
            if (s < lo) begin
                clamped = 1'b1;
                return lo;
            end
            return s;
        end
        r = ((s % m) + m) % m;
        if (r > hi) r -= m;
        return r;
    endfunction

    task automatic modelReset();
        for (int k = 0; k < 3; k++) begin
            m_acc[k]  = 0;
            m_sat[k]  = 1'b0;
            m_res[k]  = 0;
            m_rsat[k] = 1'b0;
        end
        m_rvalid = 1'b0;
        m_shadow = 0;
        m_active = 0;
        m_dout   = 0;
        m_doutv  = 1'b0;
    endtask

    task automatic modelStep(input bit dv, input longint din, input bit ae, input bit al,
                             input bit be, input longint bias, input bit wl, input longint win,
                             input bit ws, input bit rr);
        bit inr = !(m_rvalid && !rr);
        bit acc_beat = dv && inr && ae;
        longint s;
        longint f;
        bit clamped;
        m_doutv = dv && inr;
        if (dv && inr) m_dout = din;
        for (int k = 0; k < 3; k++) begin
            if (acc_beat) begin
                s = (be ? bias : m_acc[k]) + din * m_active;
                f = fitValue(cfg_w[k], cfg_sat[k], s, clamped);
                if (al) begin
                    m_res[k]  = f;
                    m_rsat[k] = cfg_sat[k] && ((be ? 1'b0 : m_sat[k]) || clamped);
                    m_acc[k]  = 0;
                    m_sat[k]  = 1'b0;
                end else begin
                    m_acc[k] = f;
                    m_sat[k] = (be ? 1'b0 : m_sat[k]) || clamped;
                end
            end else if (be && inr) begin
                m_acc[k] = bias;
                m_sat[k] = 1'b0;
            end
        end
        if (acc_beat && al) m_rvalid = 1'b1;
        else if (m_rvalid && rr) m_rvalid = 1'b0;
        if (ws) m_active = m_shadow;
        if (wl) m_shadow = win;
    endtask

    task automatic checkAll(input string tag);
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("%s.result%0d", tag, k), dutResult(k), m_res[k]);
            checkOutput($sformatf("%s.result_sat%0d", tag, k), longint'(result_sat[k]), longint'(m_rsat[k]));
            checkOutput($sformatf("%s.result_valid%0d", tag, k), longint'(result_valid[k]), longint'(m_rvalid));
            checkOutput($sformatf("%s.data_out_valid%0d", tag, k), longint'(data_out_valid[k]), longint'(m_doutv));
            checkOutput($sformatf("%s.data_out%0d", tag, k), longint'($signed(data_out[k])), m_dout);
        end
    endtask

    // One clock of stimulus: drive, check combinational in_ready, clock, advance model, check state.
    task automatic applyStimulus(input string tag, input bit dv, input int din, input bit ae,
                                 input bit al, input bit be, input int bias, input bit wl,
                                 input int win, input bit ws, input bit rr);
        data_in       = 8'(din);
        data_in_valid = dv;
        acc_en        = ae;
        acc_last      = al;
        bias_en       = be;
        bias_in       = 8'(bias);
        weight_load   = wl;
        weight_in     = 8'(win);
        weight_swap   = ws;
        result_ready  = rr;
        #1;
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("%s.in_ready%0d", tag, k), longint'(in_ready[k]),
                        longint'(!(m_rvalid && !rr)));
        end
        @(posedge clk);
        #1;
        modelStep(dv, longint'(din), ae, al, be, longint'(bias), wl, longint'(win), ws, rr);
        checkAll(tag);
    endtask

    task automatic idleInputs();
        data_in = '0; data_in_valid = 1'b0; acc_en = 1'b0; acc_last = 1'b0;
        bias_en = 1'b0; bias_in = '0; weight_load = 1'b0; weight_in = '0;
        weight_swap = 1'b0; result_ready = 1'b0;
    endtask

    task automatic checkCleared(input string tag);
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("%s.result_valid%0d", tag, k), longint'(result_valid[k]), 0);
            checkOutput($sformatf("%s.data_out_valid%0d", tag, k), longint'(data_out_valid[k]), 0);
            checkOutput($sformatf("%s.data_out%0d", tag, k), longint'(data_out[k]), 0);
            checkOutput($sformatf("%s.result%0d", tag, k), dutResult(k), 0);
            checkOutput($sformatf("%s.result_sat%0d", tag, k), longint'(result_sat[k]), 0);
        end
    endtask

    // Asynchronous reset raised between clock edges; outputs must clear before the next edge.
    task automatic midCycleReset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        checkCleared(tag);
        idleInputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
        modelReset();
    endtask

    initial begin
        idleInputs();
        modelReset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkCleared("reset");
        rst = 1'b0;

        // dv din ae al be bias wl win ws rr
        applyStimulus("tp1_load",  0, 0, 0, 0, 0, 0, 1, 3, 0, 0);
        applyStimulus("tp1_swap",  0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        applyStimulus("tp1_bias",  0, 0, 0, 0, 1, 5, 0, 0, 0, 0);
        applyStimulus("tp1_beat2", 1, 2, 1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus("tp1_beat4", 1, 4, 1, 1, 0, 0, 0, 0, 0, 0);
        checkOutput("tp1_result", dutResult(0), 23);
        checkOutput("tp1_result_sat", longint'(result_sat[0]), 0);
        checkOutput("tp1_result_valid", longint'(result_valid[0]), 1);

        for (int i = 0; i < 4; i++) begin
            applyStimulus("bp_stall", 1, 9, 1, 0, 0, 0, 0, 0, 0, 0);
            checkOutput("bp_in_ready", longint'(in_ready[0]), 0);
            checkOutput("bp_result_hold", dutResult(0), 23);
        end
        applyStimulus("bp_pop", 1, 1, 1, 0, 1, 0, 0, 0, 0, 1);
        checkOutput("bp_pop_accepted", longint'(data_out_valid[0]), 1);
        checkOutput("bp_pop_valid", longint'(result_valid[0]), 0);

        applyStimulus("sw_load",  0, 0, 0, 0, 0, 0, 1, -2, 0, 1);
        applyStimulus("sw_mac",   1, 10, 1, 0, 1, 0, 0, 0, 1, 1);
        applyStimulus("sw_last",  1, 10, 1, 1, 0, 0, 0, 0, 0, 0);
        checkOutput("sw_result", dutResult(0), 10);

        applyStimulus("sat_load", 0, 0, 0, 0, 0, 0, 1, 127, 0, 1);
        applyStimulus("sat_swap", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        applyStimulus("sat_b1",   1, 127, 1, 0, 1, 0, 0, 0, 0, 1);
        applyStimulus("sat_b2",   1, 127, 1, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus("sat_b3",   1, 127, 1, 1, 0, 0, 0, 0, 0, 0);
        checkOutput("sat_wide_result", dutResult(0), 48387);
        checkOutput("sat16_result", dutResult(1), 32767);
        checkOutput("sat16_flag", longint'(result_sat[1]), 1);
        checkOutput("wrap16_result", dutResult(2), -17149);
        checkOutput("wrap16_flag", longint'(result_sat[2]), 0);

        applyStimulus("b2b_last", 1, 1, 1, 1, 1, 7, 0, 0, 0, 1);
        checkOutput("b2b_valid", longint'(result_valid[0]), 1);
        checkOutput("b2b_result", dutResult(0), 134);

        applyStimulus("rst_acc", 1, 3, 1, 0, 1, 4, 0, 0, 0, 1);
        midCycleReset("rst_mid_acc");
        applyStimulus("rst_w",    0, 0, 0, 0, 0, 0, 1, 50, 0, 1);
        applyStimulus("rst_wsw",  0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        applyStimulus("rst_last", 1, 2, 1, 1, 1, 1, 0, 0, 0, 0);
        applyStimulus("rst_hold", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        midCycleReset("rst_mid_hold");
        applyStimulus("one_bias", 0, 0, 0, 0, 1, -9, 0, 0, 0, 1);
        applyStimulus("one_last", 1, 55, 1, 1, 0, 0, 0, 0, 0, 1);
        checkOutput("one_result", dutResult(0), -9);

        for (int i = 0; i < 600; i++) begin
            applyStimulus("rand",
                          ($urandom % 4) != 0, int'($urandom_range(0, 255)) - 128,
                          ($urandom % 4) != 0, ($urandom % 5) == 0,
                          ($urandom % 6) == 0, int'($urandom_range(0, 255)) - 128,
                          ($urandom % 8) == 0, int'($urandom_range(0, 255)) - 128,
                          ($urandom % 10) == 0, ($urandom % 3) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
